// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared by the ALU, load/store unit, decoder and register file.
// The master side drives requests and issues. The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
);
  logic              a_valid;
  logic [AW-1:0]     a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [AW-1:0]     b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_stall;
  logic [NREG-1:0]   busy;
  logic              rf_we;
  logic [AW-1:0]     rf_sel;
  logic [DATA_W-1:0] rf_data;
  logic              wb_err;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output issue_valid, issue_rd,
    input  a_ready, b_ready, issue_stall, busy,
    input  rf_we, rf_sel, rf_data, wb_err
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  issue_valid, issue_rd,
    output a_ready, b_ready, issue_stall, busy,
    output rf_we, rf_sel, rf_data, wb_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU vs LSU)
// with a per-register busy scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  logic              r_rr_b;
  logic [NREG-1:0]   r_busy;
  logic              r_rf_we;
  logic [AW-1:0]     r_rf_sel;
  logic [DATA_W-1:0] r_rf_data;
  logic              r_wb_err;

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_gnt;
  logic [AW-1:0]     w_rd;
  logic [DATA_W-1:0] w_data;
  logic              w_set;
  logic [NREG-1:0]   w_busy_nxt;

  always_comb begin
    w_gnt_a = bus.a_valid & (~bus.b_valid | r_rr_b);
    w_gnt_b = bus.b_valid & (~bus.a_valid | ~r_rr_b);
    w_gnt   = w_gnt_a | w_gnt_b;
    w_rd    = '0;
    w_data  = '0;
    unique case (1'b1)
      w_gnt_a: begin
        w_rd   = bus.a_rd;
        w_data = bus.a_data;
      end
      w_gnt_b: begin
        w_rd   = bus.b_rd;
        w_data = bus.b_data;
      end
      default: ;
    endcase
    w_set      = bus.issue_valid & ~r_busy[bus.issue_rd];
    w_busy_nxt = r_busy;
    if (w_gnt) w_busy_nxt[w_rd] = 1'b0;
    // New writer owns the register even if its old writer retires now
    if (w_set) w_busy_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_b    <= 1'b1;
      r_busy    <= '0;
      r_rf_we   <= 1'b0;
      r_rf_sel  <= '0;
      r_rf_data <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      r_rf_we <= w_gnt;
      r_busy  <= w_busy_nxt;
      if (w_gnt) begin
        r_rf_sel  <= w_rd;
        r_rf_data <= w_data;
        r_rr_b    <= w_gnt_b;
        if (!r_busy[w_rd]) r_wb_err <= 1'b1;
      end
    end
  end

  assign bus.a_ready     = w_gnt_a;
  assign bus.b_ready     = w_gnt_b;
  assign bus.issue_stall = bus.issue_valid & r_busy[bus.issue_rd];
  assign bus.busy        = r_busy;
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_sel      = r_rf_sel;
  assign bus.rf_data     = r_rf_data;
  assign bus.wb_err      = r_wb_err;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a scoreboard of
// expected register-file writes.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [18:0] exp_q[$];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] rd, input logic [15:0] d);
    exp_q.push_back({rd, d});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && bus.rf_we) begin
      chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("wb_write", {13'd0, bus.rf_sel, bus.rf_data},
            {13'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int an;
    int bn;
    logic exp_b;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 8'h00);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_sel", bus.rf_sel, 0);
    chk("rst_data", bus.rf_data, 0);
    chk("rst_err", bus.wb_err, 0);
    rst_n = 1'b1;
    tick();

    // Single A writeback
    bus.issue_valid = 1; bus.issue_rd = 3;
    #1 chk("a_issue_stall", bus.issue_stall, 0);
    tick();
    bus.issue_valid = 0;
    chk("a_busy_set", bus.busy, 8'h08);
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 16'h1234;
    #1 chk("a_ready", bus.a_ready, 1);
    chk("a_b_ready", bus.b_ready, 0);
    push(3, 16'h1234);
    tick();
    bus.a_valid = 0;
    chk("a_we", bus.rf_we, 1);
    chk("a_sel", bus.rf_sel, 3);
    chk("a_data", bus.rf_data, 16'h1234);
    chk("a_busy_clr", bus.busy, 8'h00);
    tick();
    chk("a_we_drop", bus.rf_we, 0);
    chk("a_sel_hold", bus.rf_sel, 3);

    // Contention: last grant was A, so B, A, B, A
    bus.issue_valid = 1; bus.issue_rd = 1;
    tick();
    bus.issue_rd = 2;
    tick();
    bus.issue_valid = 0;
    chk("c_busy", bus.busy, 8'h06);
    an = 1; bn = 1;
    bus.a_valid = 1; bus.a_rd = 1; bus.a_data = 16'hA001;
    bus.b_valid = 1; bus.b_rd = 2; bus.b_data = 16'hB001;
    for (int c = 0; c < 4; c++) begin
      exp_b = (c % 2 == 0);
      #1;
      chk("c_a_ready", bus.a_ready, !exp_b);
      chk("c_b_ready", bus.b_ready, exp_b);
      if (exp_b) push(2, bus.b_data);
      else push(1, bus.a_data);
      tick();
      chk("c_we", bus.rf_we, 1);
      if (exp_b) begin
        bn++;
        bus.b_data = 16'hB000 + 16'(bn);
      end else begin
        an++;
        bus.a_data = 16'hA000 + 16'(an);
      end
    end
    bus.a_valid = 0; bus.b_valid = 0;
    chk("c_err_rewrite", bus.wb_err, 1);
    tick();
    chk("c_we_drop", bus.rf_we, 0);

    // Asynchronous reset in the middle of traffic
    for (int r = 0; r < 8; r++) begin
      bus.issue_valid = 1; bus.issue_rd = 3'(r);
      tick();
    end
    bus.issue_valid = 0;
    chk("r_busy_full", bus.busy, 8'hFF);
    bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 16'h5555;
    push(0, 16'h5555);
    tick();
    chk("r_we_before", bus.rf_we, 1);
    bus.a_rd = 1; bus.a_data = 16'h5556;
    #3 rst_n = 1'b0;
    #1;
    chk("r_busy_async", bus.busy, 8'h00);
    chk("r_we_async", bus.rf_we, 0);
    chk("r_err_async", bus.wb_err, 0);
    tick();
    bus.a_valid = 0;
    #3 rst_n = 1'b1;
    tick();
    chk("r_no_write", bus.rf_we, 0);
    chk("r_busy_after", bus.busy, 8'h00);
    bus.a_valid = 1; bus.b_valid = 1;
    #1;
    chk("r_tie_a", bus.a_ready, 1);
    chk("r_tie_b", bus.b_ready, 0);
    bus.a_valid = 0; bus.b_valid = 0;
    tick();

    // RAW stall on register 5
    bus.issue_valid = 1; bus.issue_rd = 5;
    tick();
    chk("s_busy", bus.busy, 8'h20);
    #1 chk("s_stall", bus.issue_stall, 1);
    tick();
    chk("s_busy_hold", bus.busy, 8'h20);
    bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 16'hBEEF;
    #1 chk("s_b_ready", bus.b_ready, 1);
    chk("s_stall_same", bus.issue_stall, 1);
    push(5, 16'hBEEF);
    tick();
    bus.b_valid = 0;
    chk("s_busy_clr", bus.busy, 8'h00);
    chk("s_stall_drop", bus.issue_stall, 0);
    chk("s_sel", bus.rf_sel, 5);
    tick();
    bus.issue_valid = 0;
    chk("s_busy_reset", bus.busy, 8'h20);
    chk("s_err_clean", bus.wb_err, 0);

    // Same-edge set/clear, then a stray write
    bus.issue_valid = 1; bus.issue_rd = 2;
    bus.a_valid = 1; bus.a_rd = 2; bus.a_data = 16'h2222;
    #1 chk("x_stall", bus.issue_stall, 0);
    chk("x_a_ready", bus.a_ready, 1);
    push(2, 16'h2222);
    tick();
    bus.issue_valid = 0; bus.a_valid = 0;
    chk("x_busy_set_wins", bus.busy, 8'h24);
    chk("x_err", bus.wb_err, 1);
    bus.b_valid = 1; bus.b_rd = 6; bus.b_data = 16'h6666;
    push(6, 16'h6666);
    tick();
    bus.b_valid = 0;
    chk("x_stray_we", bus.rf_we, 1);
    chk("x_stray_busy", bus.busy, 8'h24);
    tick();
    tick();
    chk("x_err_sticky", bus.wb_err, 1);
    chk("q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
